// File: rtl/midi_pkg.sv
// Shared MIDI definitions: baud timing, status-class constants, FSM state
// types and the status-byte-to-message-length decoder.
package midi_pkg;

   localparam int MIDI_BAUD_CLKS = 3200;

   localparam logic [7:0] NOTE_OFF     = 8'h80;
   localparam logic [7:0] NOTE_ON      = 8'h90;
   localparam logic [7:0] POLY_PRESS   = 8'hA0;
   localparam logic [7:0] CTRL_CHANGE  = 8'hB0;
   localparam logic [7:0] PROG_CHANGE  = 8'hC0;
   localparam logic [7:0] CHAN_PRESS   = 8'hD0;
   localparam logic [7:0] PITCH_BEND   = 8'hE0;
   localparam logic [7:0] SYS_MIN      = 8'hF0;
   localparam logic [7:0] SYS_TC_QF    = 8'hF1;
   localparam logic [7:0] SYS_SONG_POS = 8'hF2;
   localparam logic [7:0] SYS_SONG_SEL = 8'hF3;
   localparam logic [7:0] RT_MIN       = 8'hF8;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_POP,
      SEQ_SEND_BYTE,
      SEQ_DONE
   } seq_state_t;

   typedef enum logic [1:0] {
      BYTE_IDLE,
      BYTE_START,
      BYTE_DATA,
      BYTE_STOP
   } byte_state_t;

   // Total bytes on the wire for a message, status byte included.
   // SysEx is not supported, so F0/F7 and the other system bytes are singles.
   function automatic logic [1:0] msg_len(input logic [7:0] status);
      logic [1:0] len;
      len = 2'd1;
      if (status < SYS_MIN) begin
         if (status[7:4] == PROG_CHANGE[7:4] || status[7:4] == CHAN_PRESS[7:4])
            len = 2'd2;
         else
            len = 2'd3;
      end else if (status == SYS_SONG_POS) begin
         len = 2'd3;
      end else if (status == SYS_TC_QF || status == SYS_SONG_SEL) begin
         len = 2'd2;
      end
      return len;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// One 8N1 UART frame per accepted byte. A new byte may be accepted in the
// last cycle of the stop bit so consecutive frames run with no idle gap.
module uart_tx_byte
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT = MIDI_BAUD_CLKS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done,
   output logic       ready
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   byte_state_t   state;
   logic [BW-1:0] baud_cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    shift_reg;
   logic          baud_last;

   assign baud_last = (baud_cnt == BAUD_LAST);
   assign done      = (state == BYTE_STOP) && baud_last;
   assign ready     = (state == BYTE_IDLE) || done;

   // Frame FSM: start bit, eight data bits LSB first, stop bit, each one baud period long.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= BYTE_IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         tx        <= 1'b1;
      end else begin
         case (state)
            BYTE_IDLE: begin
               if (start) begin
                  state     <= BYTE_START;
                  baud_cnt  <= '0;
                  shift_reg <= data;
                  tx        <= 1'b0;
               end
            end
            BYTE_START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= BYTE_DATA;
                  tx       <= shift_reg[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            BYTE_DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 4'd7) begin
                     state <= BYTE_STOP;
                     tx    <= 1'b1;
                  end else begin
                     bit_cnt   <= bit_cnt + 4'd1;
                     shift_reg <= {1'b0, shift_reg[7:1]};
                     tx        <= shift_reg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            BYTE_STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (start) begin
                     state     <= BYTE_START;
                     shift_reg <= data;
                     tx        <= 1'b0;
                  end else begin
                     state <= BYTE_IDLE;
                     tx    <= 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: state <= BYTE_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/midi_tx.sv
// MIDI OUT transmitter: queues whole messages, applies running status and
// feeds the bytes of each message to the UART frame generator back to back.
module midi_tx
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT   = MIDI_BAUD_CLKS,
   parameter int FIFO_DEPTH     = 4,
   parameter int RUNNING_STATUS = 1
) (
   input  logic        CLK100MHZ,
   input  logic        reset,
   input  logic        msg_valid,
   input  logic [23:0] msg_data,
   output logic        msg_ready,
   output logic        midi_out,
   output logic        busy,
   output logic        msg_err,
   output logic [15:0] msg_count
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic [23:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] fifo_cnt;
   logic          fifo_empty;
   logic          push;
   logic          pop;

   seq_state_t    seq_state;
   logic [23:0]   cur_msg;
   logic [1:0]    byte_idx;
   logic [1:0]    byte_len;
   logic [7:0]    rs_status;
   logic          rs_valid;
   logic          last_pending;

   logic [23:0]   head;
   logic [7:0]    head_status;
   logic          head_is_chan;
   logic          skip_status;
   logic [7:0]    cur_byte;
   logic          last_byte;
   logic          uart_start;
   logic          uart_done;
   logic          uart_ready;

   assign msg_ready  = (fifo_cnt != CW'(FIFO_DEPTH));
   assign fifo_empty = (fifo_cnt == '0);
   assign push       = msg_valid && msg_ready && msg_data[23];
   assign pop        = (seq_state == SEQ_POP);

   assign head         = fifo_mem[rd_ptr];
   assign head_status  = head[23:16];
   assign head_is_chan = (head_status < SYS_MIN);
   assign skip_status  = (RUNNING_STATUS != 0) && head_is_chan && rs_valid
                         && (rs_status == head_status);

   assign cur_byte   = (byte_idx == 2'd0) ? cur_msg[23:16] :
                       (byte_idx == 2'd1) ? cur_msg[15:8]  : cur_msg[7:0];
   assign last_byte  = (byte_idx == byte_len - 2'd1);
   assign uart_start = (seq_state == SEQ_SEND_BYTE) && uart_ready;

   assign busy = !fifo_empty || (seq_state != SEQ_IDLE) || !uart_ready || last_pending;

   // Message storage; no reset needed since occupancy is tracked separately.
   always_ff @(posedge CLK100MHZ) begin
      if (push)
         fifo_mem[wr_ptr] <= msg_data;
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            fifo_cnt <= fifo_cnt + 1'b1;
         else if (pop && !push)
            fifo_cnt <= fifo_cnt - 1'b1;
      end
   end

   // Flag an offered message whose first byte is not a status byte.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset)
         msg_err <= 1'b0;
      else
         msg_err <= msg_valid && msg_ready && !msg_data[23];
   end

   // Sequencer: latch the head message, decide which bytes go out, hand them to the UART.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         seq_state <= SEQ_IDLE;
         cur_msg   <= '0;
         byte_idx  <= '0;
         byte_len  <= 2'd1;
         rs_status <= '0;
         rs_valid  <= 1'b0;
      end else begin
         case (seq_state)
            SEQ_IDLE: begin
               if (!fifo_empty)
                  seq_state <= SEQ_POP;
            end
            SEQ_POP: begin
               cur_msg   <= head;
               byte_len  <= msg_len(head_status);
               byte_idx  <= skip_status ? 2'd1 : 2'd0;
               seq_state <= SEQ_SEND_BYTE;
               if (RUNNING_STATUS != 0) begin
                  if (head_is_chan) begin
                     rs_status <= head_status;
                     rs_valid  <= 1'b1;
                  end else if (head_status < RT_MIN) begin
                     rs_valid <= 1'b0;
                  end
               end
            end
            SEQ_SEND_BYTE: begin
               if (uart_ready) begin
                  if (last_byte)
                     seq_state <= SEQ_DONE;
                  else
                     byte_idx <= byte_idx + 2'd1;
               end
            end
            SEQ_DONE: begin
               seq_state <= fifo_empty ? SEQ_IDLE : SEQ_POP;
            end
            default: seq_state <= SEQ_IDLE;
         endcase
      end
   end

   // A message counts as transmitted once the stop bit of its final byte has finished.
   always_ff @(posedge CLK100MHZ or posedge reset) begin
      if (reset) begin
         last_pending <= 1'b0;
         msg_count    <= '0;
      end else begin
         if (uart_done && last_pending)
            msg_count <= msg_count + 16'd1;
         if (uart_start && last_byte)
            last_pending <= 1'b1;
         else if (uart_done)
            last_pending <= 1'b0;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_tx_byte (
      .clk   (CLK100MHZ),
      .reset (reset),
      .start (uart_start),
      .data  (cur_byte),
      .tx    (midi_out),
      .done  (uart_done),
      .ready (uart_ready)
   );

endmodule

// File: tb/tb_midi_tx.sv
// Self-checking bench for midi_tx: directed scenarios plus a randomized run,
// compared against a message-level model of running status and byte counts.
module tb_midi_tx;

   localparam int CPB   = 16;
   localparam int FRAME = 10 * CPB;

   logic        CLK100MHZ;
   logic        reset;
   logic        msg_valid;
   logic [23:0] msg_data;
   logic        msg_ready;
   logic        midi_out;
   logic        busy;
   logic        msg_err;
   logic [15:0] msg_count;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   logic [7:0] rx_bytes [$];
   int         rx_t0    [$];
   bit         rx_ok    [$];

   logic [7:0] exp_bytes [$];
   int         exp_msgs;
   bit         m_rs_valid;
   logic [7:0] m_rs;

   midi_tx #(
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH(4),
      .RUNNING_STATUS(1)
   ) dut (
      .CLK100MHZ (CLK100MHZ),
      .reset     (reset),
      .msg_valid (msg_valid),
      .msg_data  (msg_data),
      .msg_ready (msg_ready),
      .midi_out  (midi_out),
      .busy      (busy),
      .msg_err   (msg_err),
      .msg_count (msg_count)
   );

   initial CLK100MHZ = 1'b0;
   always #5 CLK100MHZ = ~CLK100MHZ;

   // Line decoder: captures each frame, its start cycle and whether every cell was clean.
   initial begin
      bit         active;
      int         pos;
      int         bitn;
      int         off;
      int         t0;
      bit         ok;
      logic       cell_val;
      logic [7:0] b;
      active   = 0;
      pos      = 0;
      t0       = 0;
      ok       = 1;
      cell_val = 1'b1;
      b        = '0;
      forever begin
         @(negedge CLK100MHZ);
         cyc++;
         if (reset) begin
            active = 0;
         end else begin
            if (!active && midi_out === 1'b0) begin
               active = 1;
               pos    = 0;
               t0     = cyc;
               ok     = 1;
               b      = '0;
            end
            if (active) begin
               bitn = pos / CPB;
               off  = pos % CPB;
               if (off == 0)
                  cell_val = midi_out;
               else if (midi_out !== cell_val)
                  ok = 0;
               if (off == CPB / 2) begin
                  if (bitn == 0 && midi_out !== 1'b0) ok = 0;
                  if (bitn >= 1 && bitn <= 8) b[bitn-1] = midi_out;
                  if (bitn == 9 && midi_out !== 1'b1) ok = 0;
               end
               pos++;
               if (pos == FRAME) begin
                  rx_bytes.push_back(b);
                  rx_t0.push_back(t0);
                  rx_ok.push_back(ok);
                  active = 0;
               end
            end
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference model: bytes a message should put on the wire given the stored status.
   task automatic modelAccept(input logic [23:0] m);
      logic [7:0] st;
      int         len;
      bit         send_status;
      st = m[23:16];
      if (st < 8'h80) return;
      if (st < 8'hC0)      len = 3;
      else if (st < 8'hE0) len = 2;
      else if (st < 8'hF0) len = 3;
      else if (st == 8'hF2) len = 3;
      else if (st == 8'hF1 || st == 8'hF3) len = 2;
      else len = 1;
      send_status = 1;
      if (st < 8'hF0) begin
         if (m_rs_valid && m_rs == st) send_status = 0;
         m_rs       = st;
         m_rs_valid = 1;
      end else if (st < 8'hF8) begin
         m_rs_valid = 0;
      end
      if (send_status) exp_bytes.push_back(st);
      if (len >= 2) exp_bytes.push_back(m[15:8]);
      if (len == 3) exp_bytes.push_back(m[7:0]);
      exp_msgs++;
   endtask

   task automatic applyStimulus(input logic [23:0] m);
      int waited;
      msg_data  = m;
      msg_valid = 1'b1;
      waited    = 0;
      while (msg_ready !== 1'b1 && waited < 4000) begin
         @(posedge CLK100MHZ); #1;
         waited++;
      end
      checkOutput("push_ready", {31'b0, msg_ready}, 32'd1);
      @(posedge CLK100MHZ); #1;
      msg_valid = 1'b0;
      modelAccept(m);
      checkOutput($sformatf("msg_err_%06h", m), {31'b0, msg_err}, {31'b0, ~m[23]});
   endtask

   task automatic doReset();
      reset     = 1'b1;
      msg_valid = 1'b0;
      repeat (3) @(posedge CLK100MHZ);
      #1;
      reset = 1'b0;
      rx_bytes.delete();
      rx_t0.delete();
      rx_ok.delete();
      exp_bytes.delete();
      exp_msgs   = 0;
      m_rs_valid = 0;
      m_rs       = '0;
   endtask

   task automatic waitIdle(input int limit);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(posedge CLK100MHZ); #1;
         n++;
      end
      checkOutput("busy_idle", {31'b0, busy}, 32'd0);
   endtask

   function automatic logic [7:0] rxByte(input int i);
      if (i < rx_bytes.size()) return rx_bytes[i];
      return 8'hxx;
   endfunction

   task automatic checkRx(input string tag);
      checkOutput({tag, "_nbytes"}, rx_bytes.size(), exp_bytes.size());
      for (int i = 0; i < exp_bytes.size(); i++) begin
         checkOutput($sformatf("%s_byte%0d", tag, i), {24'b0, rxByte(i)}, {24'b0, exp_bytes[i]});
         if (i < rx_ok.size())
            checkOutput($sformatf("%s_frame%0d", tag, i), {31'b0, rx_ok[i]}, 32'd1);
      end
      checkOutput({tag, "_count"}, {16'b0, msg_count}, exp_msgs);
   endtask

   task automatic checkGaps(input string tag);
      for (int i = 1; i < rx_t0.size(); i++)
         checkOutput($sformatf("%s_gap%0d", tag, i), rx_t0[i] - rx_t0[i-1], FRAME);
   endtask

   logic [7:0] status_pool [0:13];

   initial begin
      int  lat;
      bit  low_seen;
      int  rx_before;
      logic [7:0] st;

      status_pool = '{8'h90, 8'h90, 8'h91, 8'h80, 8'hB0, 8'hC0, 8'hD0,
                      8'hE0, 8'hF8, 8'hF3, 8'hF1, 8'hF2, 8'hF6, 8'h3C};
      reset     = 1'b1;
      msg_valid = 1'b0;
      msg_data  = '0;
      exp_msgs  = 0;
      m_rs_valid = 0;
      m_rs      = '0;

      // Reset values
      repeat (3) @(posedge CLK100MHZ);
      #1;
      checkOutput("rst_midi_out",  {31'b0, midi_out},  32'd1);
      checkOutput("rst_msg_ready", {31'b0, msg_ready}, 32'd1);
      checkOutput("rst_busy",      {31'b0, busy},      32'd0);
      checkOutput("rst_msg_err",   {31'b0, msg_err},   32'd0);
      checkOutput("rst_msg_count", {16'b0, msg_count}, 32'd0);
      reset = 1'b0;

      // Quiet line after reset
      low_seen = 0;
      repeat (5000) begin
         @(posedge CLK100MHZ); #1;
         if (midi_out !== 1'b1) low_seen = 1;
      end
      checkOutput("idle_line_high", {31'b0, low_seen}, 32'd0);
      checkOutput("idle_no_frames", rx_bytes.size(), 32'd0);

      // Note On with latency and frame timing
      doReset();
      applyStimulus(24'h903C64);
      lat = 0;
      while (midi_out !== 1'b0 && lat < 10) begin
         @(posedge CLK100MHZ); #1;
         lat++;
      end
      checkOutput("note_on_latency_le3", {31'b0, (lat <= 3)}, 32'd1);
      waitIdle(2000);
      checkRx("note_on");
      checkOutput("note_on_b0", {24'b0, rxByte(0)}, 32'h90);
      checkOutput("note_on_b1", {24'b0, rxByte(1)}, 32'h3C);
      checkOutput("note_on_b2", {24'b0, rxByte(2)}, 32'h64);
      checkGaps("note_on");
      checkOutput("note_on_count", {16'b0, msg_count}, 32'd1);

      // Running status across two Note Ons
      doReset();
      applyStimulus(24'h903C64);
      applyStimulus(24'h903E50);
      waitIdle(3000);
      checkRx("rs_pair");
      checkOutput("rs_pair_nbytes5", rx_bytes.size(), 32'd5);
      checkOutput("rs_pair_b3", {24'b0, rxByte(3)}, 32'h3E);
      checkGaps("rs_pair");

      // Realtime byte keeps running status
      doReset();
      applyStimulus(24'h903C64);
      applyStimulus(24'hF80000);
      applyStimulus(24'h903E50);
      waitIdle(3000);
      checkRx("rs_rt");
      checkOutput("rs_rt_b3", {24'b0, rxByte(3)}, 32'hF8);
      checkOutput("rs_rt_b4", {24'b0, rxByte(4)}, 32'h3E);

      // System common byte invalidates running status
      doReset();
      applyStimulus(24'h903C64);
      applyStimulus(24'hF31200);
      applyStimulus(24'h903C00);
      waitIdle(3000);
      checkRx("rs_inval");
      checkOutput("rs_inval_b5", {24'b0, rxByte(5)}, 32'h90);

      // Two-byte message, then a message without a status byte
      doReset();
      applyStimulus(24'hC00577);
      waitIdle(2000);
      checkRx("prog_chg");
      checkOutput("prog_chg_nbytes2", rx_bytes.size(), 32'd2);
      rx_before = rx_bytes.size();
      applyStimulus(24'h3C6400);
      checkOutput("err_ready_kept", {31'b0, msg_ready}, 32'd1);
      checkOutput("err_not_busy", {31'b0, busy}, 32'd0);
      @(posedge CLK100MHZ); #1;
      checkOutput("err_one_cycle", {31'b0, msg_err}, 32'd0);
      repeat (400) @(posedge CLK100MHZ);
      #1;
      checkOutput("err_nothing_sent", rx_bytes.size(), rx_before);

      // FIFO full: five accepts fill it (one popped), sixth waits
      doReset();
      applyStimulus(24'h903C64);
      applyStimulus(24'h803C00);
      applyStimulus(24'hB00764);
      applyStimulus(24'hC00500);
      applyStimulus(24'hE00040);
      checkOutput("fifo_full_ready", {31'b0, msg_ready}, 32'd0);
      applyStimulus(24'h913C64);
      waitIdle(6000);
      checkRx("fifo_full");
      checkGaps("fifo_full");

      // Reset during a data bit
      doReset();
      applyStimulus(24'h903C64);
      applyStimulus(24'h913C64);
      applyStimulus(24'h923C64);
      lat = 0;
      while (midi_out !== 1'b0 && lat < 20) begin
         @(posedge CLK100MHZ); #1;
         lat++;
      end
      repeat (CPB + CPB / 2) @(posedge CLK100MHZ);
      #1;
      rx_before = rx_bytes.size();
      reset = 1'b1;
      #1;
      checkOutput("midrst_line_high", {31'b0, midi_out},  32'd1);
      checkOutput("midrst_not_busy",  {31'b0, busy},      32'd0);
      checkOutput("midrst_ready",     {31'b0, msg_ready}, 32'd1);
      repeat (3) @(posedge CLK100MHZ);
      #1;
      reset = 1'b0;
      repeat (1000) @(posedge CLK100MHZ);
      #1;
      checkOutput("midrst_fifo_empty", rx_bytes.size(), rx_before);
      checkOutput("midrst_count", {16'b0, msg_count}, 32'd0);

      // Randomized message stream
      doReset();
      for (int i = 0; i < 20; i++) begin
         st = status_pool[$urandom_range(0, 13)];
         applyStimulus({st, 1'b0, 7'($urandom_range(0, 127)), 1'b0, 7'($urandom_range(0, 127))});
         repeat ($urandom_range(0, 3)) @(posedge CLK100MHZ);
         #1;
      end
      waitIdle(20000);
      checkRx("random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
